// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter and sequencer in front of a word-wide memory.
// Optional round-robin arbitration: define ARB_ROUND_ROBIN_EN (default is fixed LS-over-IF priority).
module mem_arbiter #(
  parameter int unsigned AWIDTH    = 32,
  parameter int unsigned DWIDTH    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h01000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [1:0]        ls_size_i,
  input  logic [AWIDTH-1:0] ls_addr_i,
  input  logic [DWIDTH-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DWIDTH-1:0] ls_rdata_o,
  output logic              ls_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_RMW_RD = 3'd2,
    S_RMW_WR = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic              r_is_ls;
  logic              r_we;
  logic [1:0]        r_size;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_wdata;
  logic [DWIDTH-1:0] r_word;
  logic              r_mis;

  logic              w_idle;
  logic              w_ls_pri;
  logic              w_ls_mis;
  logic              w_ls_sub;
  logic [4:0]        w_shamt;
  logic [DWIDTH-1:0] w_shifted;
  logic [DWIDTH-1:0] w_load;
  logic [DWIDTH-1:0] w_merged;
  logic [AWIDTH-1:0] w_word_addr;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers whether LS received the most recent grant; reset points at IF.
  logic r_last_ls;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_last_ls <= 1'b0;
    else if (if_gnt_o || ls_gnt_o) r_last_ls <= ls_gnt_o;
  end
  assign w_ls_pri = ~r_last_ls;
`else
  assign w_ls_pri = 1'b1;
`endif

  // Grants are only possible in IDLE and are suppressed while reset is held.
  assign w_idle   = (r_state == S_IDLE) && !rst;
  assign ls_gnt_o = w_idle && ls_req_i && (w_ls_pri || !if_req_i);
  assign if_gnt_o = w_idle && if_req_i && !(ls_req_i && w_ls_pri);

  assign w_ls_mis = (ls_size_i == 2'b01) ? ls_addr_i[0] :
                    (ls_size_i[1] && (ls_addr_i[1:0] != 2'b00));
  assign w_ls_sub = ls_we_i && !ls_size_i[1];

  assign w_word_addr = {r_addr[AWIDTH-1:2], 2'b00};
  assign w_shamt     = {r_addr[1:0], 3'b000};
  assign w_shifted   = r_word >> w_shamt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (ls_gnt_o) begin
          if (w_ls_mis)      w_next = S_RESP;
          else if (w_ls_sub) w_next = S_RMW_RD;
          else               w_next = S_ACCESS;
        end else if (if_gnt_o) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: w_next = S_RESP;
      S_RMW_RD: w_next = S_RMW_WR;
      S_RMW_WR: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Latch the winner's request fields; capture every memory read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_ls <= 1'b0;
      r_we    <= 1'b0;
      r_size  <= 2'b10;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mis   <= 1'b0;
      r_word  <= '0;
    end else begin
      if (ls_gnt_o) begin
        r_is_ls <= 1'b1;
        r_we    <= ls_we_i;
        r_size  <= ls_size_i;
        r_addr  <= ls_addr_i;
        r_wdata <= ls_wdata_i;
        r_mis   <= w_ls_mis;
      end else if (if_gnt_o) begin
        r_is_ls <= 1'b0;
        r_we    <= 1'b0;
        r_size  <= 2'b10;
        r_addr  <= if_addr_i;
        r_wdata <= '0;
        r_mis   <= 1'b0;
      end
      if (mem_read_en_o) r_word <= mem_data_i;
    end
  end

  // Store-byte merge for RMW and right-aligned, zero-extended load data.
  always_comb begin
    w_merged = r_word;
    case (r_size)
      2'b00:   w_merged[w_shamt +: 8]               = r_wdata[7:0];
      2'b01:   w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: w_merged = r_word;
    endcase
  end

  always_comb begin
    case (r_size)
      2'b00:   w_load = DWIDTH'(w_shifted[7:0]);
      2'b01:   w_load = DWIDTH'(w_shifted[15:0]);
      default: w_load = w_shifted;
    endcase
  end

  always_comb begin
    mem_addr_o     = AWIDTH'(BASE_ADDR);
    mem_data_o     = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    if_rvalid_o    = 1'b0;
    if_rdata_o     = '0;
    ls_rvalid_o    = 1'b0;
    ls_rdata_o     = '0;
    ls_err_o       = 1'b0;
    case (r_state)
      S_ACCESS: begin
        mem_addr_o = w_word_addr;
        if (r_we) begin
          mem_write_en_o = 1'b1;
          mem_data_o     = r_wdata;
        end else begin
          mem_read_en_o  = 1'b1;
        end
      end
      S_RMW_RD: begin
        mem_addr_o    = w_word_addr;
        mem_read_en_o = 1'b1;
      end
      S_RMW_WR: begin
        mem_addr_o     = w_word_addr;
        mem_write_en_o = 1'b1;
        mem_data_o     = w_merged;
      end
      S_RESP: begin
        if (r_is_ls) begin
          ls_rvalid_o = 1'b1;
          ls_err_o    = r_mis;
          ls_rdata_o  = (r_mis || r_we) ? '0 : w_load;
        end else begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = r_word;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 256-word behavioural memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req, ls_we;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [31:0] ls_rdata_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic        mem_read_en_o, mem_write_en_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:255];
  int          wr_cnt = 0;
  int          en_cnt = 0;
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = 8'd0;
  logic [31:0] pre_data = 32'd0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_i      (if_req),
    .if_addr_i     (if_addr),
    .if_gnt_o      (if_gnt_o),
    .if_rvalid_o   (if_rvalid_o),
    .if_rdata_o    (if_rdata_o),
    .ls_req_i      (ls_req),
    .ls_we_i       (ls_we),
    .ls_size_i     (ls_size),
    .ls_addr_i     (ls_addr),
    .ls_wdata_i    (ls_wdata),
    .ls_gnt_o      (ls_gnt_o),
    .ls_rvalid_o   (ls_rvalid_o),
    .ls_rdata_o    (ls_rdata_o),
    .ls_err_o      (ls_err_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_read_en_o (mem_read_en_o),
    .mem_write_en_o(mem_write_en_o),
    .mem_data_i    (mem_data_i)
  );

  assign mem_data_i = mem[mem_addr_o[9:2]];

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end else if (mem_write_en_o) begin
      mem[mem_addr_o[9:2]] <= mem_data_o;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_read_en_o || mem_write_en_o) en_cnt <= en_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    pre_idx  = 8'(idx);
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  // Issue one LS request; lat = cycles from grant to rvalid.
  task automatic ls_xact(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic err);
    int n;
    ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = addr; ls_wdata = wd;
    #1;
    n = 0;
    while (!ls_gnt_o && n < 10) begin tick(); n++; end
    check("ls_gnt", 32'(ls_gnt_o), 32'd1);
    tick();
    ls_req = 1'b0;
    lat = 1;
    while (!ls_rvalid_o && lat < 10) begin tick(); lat++; end
    rd  = ls_rdata_o;
    err = ls_err_o;
    tick();
  endtask

  task automatic if_xact(input logic [31:0] addr, output int lat, output logic [31:0] rd);
    int n;
    if_req = 1'b1; if_addr = addr;
    #1;
    n = 0;
    while (!if_gnt_o && n < 10) begin tick(); n++; end
    check("if_gnt", 32'(if_gnt_o), 32'd1);
    tick();
    if_req = 1'b0;
    lat = 1;
    while (!if_rvalid_o && lat < 10) begin tick(); lat++; end
    rd = if_rdata_o;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int          lat, w0, e0, ng, cyc, both;
    logic [31:0] rd;
    logic        err;
    logic [3:0]  seq, seq_exp;

    rst = 1'b1; if_req = 1'b1; if_addr = 32'h01000000;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h01000000; ls_wdata = 32'd0;
    tick(); tick();
    check("rst_if_gnt",   32'(if_gnt_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'h01000000);
    check("rst_ren",      32'(mem_read_en_o), 32'd0);
    check("rst_wen",      32'(mem_write_en_o), 32'd0);
    if_req = 1'b0;
    rst    = 1'b0;
    tick();
    check("idle_mem_data", mem_data_o, 32'd0);
    check("idle_ls_rvalid", 32'(ls_rvalid_o), 32'd0);
    check("idle_ls_err",    32'(ls_err_o), 32'd0);
    check("idle_if_rdata",  if_rdata_o, 32'd0);

    // Fetch with per-cycle timing checks
    preload(1, 32'hDEADBEEF);
    if_req = 1'b1; if_addr = 32'h01000004;
    #1;
    check("fetch_gnt",    32'(if_gnt_o), 32'd1);
    check("fetch_no_ls",  32'(ls_gnt_o), 32'd0);
    tick();
    if_req = 1'b0;
    check("fetch_t1_addr",   mem_addr_o, 32'h01000004);
    check("fetch_t1_ren",    32'(mem_read_en_o), 32'd1);
    check("fetch_t1_rvalid", 32'(if_rvalid_o), 32'd0);
    tick();
    check("fetch_t2_rvalid", 32'(if_rvalid_o), 32'd1);
    check("fetch_t2_rdata",  if_rdata_o, 32'hDEADBEEF);
    check("fetch_t2_addr",   mem_addr_o, 32'h01000000);
    tick();
    check("fetch_t3_rvalid", 32'(if_rvalid_o), 32'd0);
    check("fetch_t3_rdata",  if_rdata_o, 32'd0);

    // Word store then load
    w0 = wr_cnt;
    ls_xact(1'b1, 2'b10, 32'h01000010, 32'h12345678, lat, rd, err);
    check("wst_lat",    32'(lat), 32'd2);
    check("wst_rdata",  rd, 32'd0);
    check("wst_err",    32'(err), 32'd0);
    check("wst_writes", 32'(wr_cnt - w0), 32'd1);
    check("wst_mem",    mem[4], 32'h12345678);
    ls_xact(1'b0, 2'b10, 32'h01000010, 32'd0, lat, rd, err);
    check("wld_lat",   32'(lat), 32'd2);
    check("wld_rdata", rd, 32'h12345678);

    // Byte store RMW and sub-word loads
    preload(8, 32'hAABBCCDD);
    w0 = wr_cnt;
    ls_xact(1'b1, 2'b00, 32'h01000022, 32'h0000005A, lat, rd, err);
    check("bst_lat",    32'(lat), 32'd3);
    check("bst_writes", 32'(wr_cnt - w0), 32'd1);
    check("bst_mem",    mem[8], 32'hAA5ACCDD);
    ls_xact(1'b0, 2'b01, 32'h01000022, 32'd0, lat, rd, err);
    check("hld_lat",   32'(lat), 32'd2);
    check("hld_rdata", rd, 32'h0000AA5A);
    ls_xact(1'b0, 2'b00, 32'h01000021, 32'd0, lat, rd, err);
    check("bld_rdata", rd, 32'h000000CC);
    ls_xact(1'b1, 2'b01, 32'h01000020, 32'hFFFFBEEF, lat, rd, err);
    check("hst_lat", 32'(lat), 32'd3);
    check("hst_mem", mem[8], 32'hAA5ABEEF);
    ls_xact(1'b0, 2'b11, 32'h01000020, 32'd0, lat, rd, err);
    check("sz3_rdata", rd, 32'hAA5ABEEF);
    ls_xact(1'b0, 2'b00, 32'h01000023, 32'd0, lat, rd, err);
    check("bld3_rdata", rd, 32'h000000AA);

    // Misaligned accesses never touch memory
    e0 = en_cnt;
    ls_xact(1'b0, 2'b10, 32'h01000001, 32'd0, lat, rd, err);
    check("mis_w_lat",   32'(lat), 32'd1);
    check("mis_w_err",   32'(err), 32'd1);
    check("mis_w_rdata", rd, 32'd0);
    ls_xact(1'b1, 2'b01, 32'h01000023, 32'h00001234, lat, rd, err);
    check("mis_h_lat",  32'(lat), 32'd1);
    check("mis_h_err",  32'(err), 32'd1);
    check("mis_no_en",  32'(en_cnt - e0), 32'd0);
    check("mis_mem",    mem[8], 32'hAA5ABEEF);

    // Reset during RMW_RD abandons the store
    preload(12, 32'h11223344);
    w0 = wr_cnt;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h01000030; ls_wdata = 32'h77;
    #1;
    check("rmw_gnt", 32'(ls_gnt_o), 32'd1);
    tick();
    ls_req = 1'b0;
    check("rmwrd_ren", 32'(mem_read_en_o), 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_ren",    32'(mem_read_en_o), 32'd0);
    check("rstmid_addr",   mem_addr_o, 32'h01000000);
    check("rstmid_rvalid", 32'(ls_rvalid_o), 32'd0);
    tick();
    check("rstmid_wen", 32'(mem_write_en_o), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rstmid_rvalid2", 32'(ls_rvalid_o), 32'd0);
    tick();
    check("rstmid_writes", 32'(wr_cnt - w0), 32'd0);
    check("rstmid_mem",    mem[12], 32'h11223344);
    if_xact(32'h01000030, lat, rd);
    check("postrst_lat",   32'(lat), 32'd2);
    check("postrst_rdata", rd, 32'h11223344);

    // Conflict with both requests held high; last grant was IF
    if_req = 1'b1; if_addr = 32'h01000004;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h01000010;
    #1;
    ng = 0; cyc = 0; both = 0; seq = 4'b0000;
    while (ng < 4 && cyc < 40) begin
      if (if_gnt_o && ls_gnt_o) both++;
      if (if_gnt_o || ls_gnt_o) begin
        seq[ng] = ls_gnt_o;
        ng++;
      end
      tick();
      cyc++;
    end
    if_req = 1'b0; ls_req = 1'b0;
    tick(); tick(); tick();
`ifdef ARB_ROUND_ROBIN_EN
    seq_exp = 4'b0101;
`else
    seq_exp = 4'b1111;
`endif
    check("conf_count", 32'(ng), 32'd4);
    check("conf_both",  32'(both), 32'd0);
    check("conf_seq",   32'(seq), 32'(seq_exp));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
